// File: rtl/pipe_reg_chain_pkg.sv
// Shared definitions for the pipeline register chain.
// Lane width and lane count defaults come from the CORDIC datapath
// (x, y, z lanes of 16-bit signed words). count_width() sizes the
// occupancy counter so it can hold 0..depth inclusive.
package pipe_reg_chain_pkg;

  localparam int WORD_WIDTH_DEF = 16;
  localparam int LANES_DEF      = 3;
  localparam int BEAT_WIDTH_DEF = LANES_DEF * WORD_WIDTH_DEF;

  // Width needed to represent the values 0..depth.
  function automatic int count_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// pipe_reg_stage: one elastic stage of the chain (valid bit + data word).
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   flush      clears the valid bit; data is left untouched
//   up_valid   upstream stage (or chain input) holds a beat
//   up_data    upstream beat
//   load       this stage has room this cycle (empty, or its beat leaves)
//   adv        this stage's beat moves downstream this cycle
//   valid      stage occupied
//   data       stage contents, held stable while not loading
module pipe_reg_stage
  import pipe_reg_chain_pkg::*;
#(
  parameter int WIDTH = BEAT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             load,
  input  logic             adv,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load && up_valid) begin
      valid <= 1'b1;
      data  <= up_data;
    end else if (adv) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH elastic register stages carrying LANES signed words
// per beat, with backpressure, bubble collapsing, flush and an occupancy count.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   flush      clear all stages next edge; blocks input this cycle
//   in_valid   upstream beat present
//   in_ready   chain accepts a beat this cycle (combinational from out_ready)
//   in_data    beat, lane i at [i*WORD_WIDTH +: WORD_WIDTH]
//   out_valid  beat present at the last stage
//   out_ready  downstream accepts the beat
//   out_data   last stage contents
//   count      number of occupied stages, 0..DEPTH
//
// Handshake: a beat moves across an interface only in a cycle where valid and
// ready are both high. A producer holding valid keeps its data stable until the
// transfer; out_data is never changed while out_valid=1 and out_ready=0.
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int DEPTH      = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES*WORD_WIDTH-1:0]       in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*WORD_WIDTH-1:0]       out_data,
  output logic [count_width(DEPTH)-1:0]     count
);

  localparam int BW = LANES * WORD_WIDTH;
  localparam int CW = count_width(DEPTH);

  if (DEPTH < 1) begin : g_depth_check
    $error("pipe_reg_chain: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] up_v;
  logic [BW-1:0]    d    [DEPTH];
  logic [BW-1:0]    up_d [DEPTH];

  // load[k] = "stage k has room": empty, or its beat leaves this cycle.
  // A stage advances when the next one has room, so ready ripples back from
  // out_ready through every stage in the same cycle. An empty stage always
  // has room, which is what collapses bubbles under downstream stall.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    assign load[k] = ~v[k] | adv[k];

    if (k == DEPTH - 1) begin : g_last
      assign adv[k] = v[k] & out_ready;
    end else begin : g_mid
      assign adv[k] = v[k] & load[k+1];
    end

    if (k == 0) begin : g_first
      assign up_v[k] = in_valid;
      assign up_d[k] = in_data;
    end else begin : g_chain
      assign up_v[k] = v[k-1];
      assign up_d[k] = d[k-1];
    end

    pipe_reg_stage #(.WIDTH(BW)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (up_v[k]),
      .up_data  (up_d[k]),
      .load     (load[k]),
      .adv      (adv[k]),
      .valid    (v[k]),
      .data     (d[k])
    );
  end

  // Flush blocks input so the beat offered during a flush is not consumed.
  assign in_ready  = ~flush & load[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  logic accept;
  logic emit;
  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // Tracks popcount(v) incrementally; accept and emit together cancel.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else begin
      case ({accept, emit})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
module tb_pipe_reg_chain;

  localparam int W  = 16;
  localparam int L  = 3;
  localparam int D  = 3;
  localparam int BW = W * L;
  localparam int CW = $clog2(D + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [CW-1:0] count;

  pipe_reg_chain #(.WORD_WIDTH(W), .LANES(L), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The chain is a FIFO of beats, each sitting at a slot position 0..D-1.
  // Each cycle the oldest beat leaves if it is at the end and downstream is
  // ready; every other beat steps one slot forward unless the beat ahead of it
  // ends up directly in front.
  typedef struct {
    logic [BW-1:0] data;
    int            pos;
  } beat_t;

  beat_t mq[$];

  function automatic void advance(input bit oready, output bit em);
    int limit;
    limit = D - 1;
    em = 1'b0;
    foreach (mq[i]) begin
      if (i == 0 && mq[0].pos == D - 1 && oready) begin
        em = 1'b1;
      end else begin
        if (mq[i].pos < limit) mq[i].pos = mq[i].pos + 1;
        limit = mq[i].pos - 1;
      end
    end
  endfunction

  function automatic bit ready_pred();
    beat_t saved[$];
    bit em;
    bit r;
    if (flush) return 1'b0;
    saved = mq;
    advance(out_ready, em);
    if (em) void'(mq.pop_front());
    r = (mq.size() == 0) || (mq[mq.size()-1].pos != 0);
    mq = saved;
    return r;
  endfunction

  always @(posedge clk) begin
    bit acc;
    bit em;
    if (rst || flush) begin
      mq.delete();
    end else begin
      acc = in_valid && ready_pred();
      advance(out_ready, em);
      if (em) void'(mq.pop_front());
      if (acc) mq.push_back('{data: in_data, pos: 0});
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [BW-1:0] got_q[$];
  logic [BW-1:0] exp_q[$];

  always @(negedge clk) begin
    bit mv;
    if (chk_en && !rst) begin
      mv = (mq.size() > 0) && (mq[0].pos == D - 1);
      chk("out_valid", out_valid, mv);
      if (mv) chk("out_data", out_data, mq[0].data);
      chk("count", count, mq.size());
      chk("in_ready", in_ready, ready_pred());
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
  end

  task automatic check_got(input string name);
    chk({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({name, "_beat"}, got_q[i], exp_q[i]);
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [BW-1:0] mk(input int n);
    return {16'(n + 200), 16'(n + 100), 16'(n)};
  endfunction

  task automatic set_in(input bit iv, input logic [BW-1:0] dd, input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = dd;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_in(1'b0, '0, 1'b1, 1'b0);
    repeat (6) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int idx;
    bit hs;
    logic [BW-1:0] e0;
    logic [BW-1:0] e1;

    rst = 1'b1;
    set_in(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("init_out_valid", out_valid, 0);
    chk("init_out_data", out_data, 0);
    chk("init_count", count, 0);
    chk("init_in_ready", in_ready, 1);
    chk_en = 1'b1;

    // Streaming: beat 1 visible 3 edges after it is offered, then 1/cycle.
    got_q.delete(); exp_q.delete();
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, mk(i), 1'b1, 1'b0);
      exp_q.push_back(mk(i));
      tick();
      if (i == 2) chk("lat_early", out_valid, 0);
      if (i == 3) begin
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, mk(1));
      end
    end
    drain();
    check_got("stream");

    // Backpressure: 5 offered, 3 fit, output frozen on the first.
    got_q.delete(); exp_q.delete();
    for (int i = 11; i <= 15; i++) exp_q.push_back(mk(i));
    idx = 11;
    for (int c = 0; c < 5; c++) begin
      set_in(1'b1, mk(idx), 1'b0, 1'b0);
      @(negedge clk);
      hs = in_ready;
      tick();
      if (hs) idx++;
    end
    chk("bp_accepted", idx - 11, 3);
    set_in(1'b1, mk(idx), 1'b0, 1'b0);
    #1;
    chk("bp_in_ready", in_ready, 0);
    chk("bp_count", count, 3);
    chk("bp_model_count", mq.size(), 3);
    chk("bp_frozen", out_data, mk(11));
    for (int c = 0; c < 20 && idx <= 15; c++) begin
      set_in(1'b1, mk(idx), 1'b1, 1'b0);
      @(negedge clk);
      hs = in_ready;
      tick();
      if (hs) idx++;
    end
    chk("bp_all_accepted", idx, 16);
    drain();
    check_got("backpressure");

    // Bubble collapse: stages hold 1,0,1 with the output stalled.
    got_q.delete(); exp_q.delete();
    exp_q.push_back(mk(21)); exp_q.push_back(mk(22)); exp_q.push_back(mk(23));
    set_in(1'b1, mk(21), 1'b0, 1'b0); tick();
    set_in(1'b0, '0, 1'b0, 1'b0);     tick();
    set_in(1'b1, mk(22), 1'b0, 1'b0); tick();
    set_in(1'b1, mk(23), 1'b0, 1'b0);
    #1;
    chk("bub_in_ready", in_ready, 1);
    chk("bub_count_before", count, 2);
    tick();
    chk("bub_count", count, 3);
    chk("bub_out_valid", out_valid, 1);
    chk("bub_out_data", out_data, mk(21));
    drain();
    check_got("bubble");

    // Flush with two beats held and a beat offered.
    got_q.delete(); exp_q.delete();
    set_in(1'b1, mk(31), 1'b0, 1'b0); tick();
    set_in(1'b1, mk(32), 1'b0, 1'b0); tick();
    chk("fl_count_before", count, 2);
    set_in(1'b1, mk(33), 1'b0, 1'b1);
    #1;
    chk("fl_in_ready", in_ready, 0);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("fl_count", count, 0);
    chk("fl_out_valid", out_valid, 0);
    exp_q.push_back(mk(34)); exp_q.push_back(mk(35));
    set_in(1'b1, mk(34), 1'b1, 1'b0); tick();
    set_in(1'b1, mk(35), 1'b1, 1'b0); tick();
    drain();
    check_got("after_flush");

    // Extreme lane values must come out bit-exact in their lanes.
    got_q.delete(); exp_q.delete();
    e0 = {16'hFFFF, 16'h7FFF, 16'h8000};
    e1 = {16'h8000, 16'hFFFF, 16'h7FFF};
    exp_q.push_back(e0); exp_q.push_back(e1);
    set_in(1'b1, e0, 1'b1, 1'b0); tick();
    set_in(1'b1, e1, 1'b1, 1'b0); tick();
    drain();
    check_got("extreme");
    if (got_q.size() >= 1) begin
      chk("ext_lane0", got_q[0][15:0],  16'h8000);
      chk("ext_lane1", got_q[0][31:16], 16'h7FFF);
      chk("ext_lane2", got_q[0][47:32], 16'hFFFF);
    end else begin
      chk("ext_present", got_q.size(), 2);
    end

    // Reset mid-traffic discards in-flight beats.
    set_in(1'b1, mk(41), 1'b0, 1'b0); tick();
    set_in(1'b1, mk(42), 1'b0, 1'b0); tick();
    rst = 1'b1;
    set_in(1'b1, mk(43), 1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    set_in(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    got_q.delete(); exp_q.delete();
    exp_q.push_back(mk(44));
    set_in(1'b1, mk(44), 1'b1, 1'b0); tick();
    drain();
    check_got("after_reset");

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
